hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Decode-stage hazard/stall scheduler for the Mini-RISC-V pipeline. Produces the ID-stage
//  branch-operand forward selects (00=ALU result, 01=WB result, 10=divider result, 11=regfile),
//  and inserts stall/bubble cycles for load-use, branch-on-ALU and multi-cycle divide hazards.
//  It also sequences the divider start/ready handshake. Sits beside the decoder and
//  drives IF/ID hold and ID/EX bubble controls.
// PARAMETERS
//  REG_AW       5   register address width
//  DIV_TIMEOUT  40  max cycles in DIV_BUSY before forced release (>=2)
// PORTS
//  clk              in   1       core clock
//  Rst              in   1       reset, synchronous, active-high
//  id_rs1/id_rs2    in   REG_AW  ID source register addresses
//  id_use_rs1/rs2   in   1       ID instr reads rs1/rs2
//  id_is_branch     in   1       ID instr is conditional branch (compares in ID)
//  ex_rd            in   REG_AW  ID/EX dest reg;  ex_regwrite, ex_memread, ex_is_div in 1 each
//  exmem_rd         in   REG_AW  EX/MEM dest;     exmem_regwrite, exmem_memread, exmem_is_div in 1
//  memwb_rd         in   REG_AW  MEM/WB dest;     memwb_regwrite in 1
//  div_ready        in   1       divider result valid (level, held until next div_start)
//  div_start        out  1       one-cycle divider launch pulse
//  stall_if, stall_id out 1      hold PC and IF/ID register
//  bubble_ex        out  1       zero control fields entering ID/EX
//  fwd_sel1/sel2    out  2       ID branch operand selects (encoding above)
//  div_timeout      out  1       sticky: a divide was released by timeout
// BEHAVIOUR
//  Reset (sync, Rst=1): state RUN, stall_cnt=0, div_cnt=0, div_timeout=0; all stall/bubble/div_start 0.
//  Match rule: id_rsN matches X_rd iff id_use_rsN && X_rd!=0 && id_rsN==X_rd.
//  fwd_selN (combinational, every cycle): exmem match && exmem_regwrite && !exmem_memread:
//    10 if exmem_is_div else 00; else memwb match && memwb_regwrite: 01; else 11.
//  FSM states RUN, STALL, DIV_START, DIV_BUSY. Priority div > load > branch.
//   RUN: ex_is_div && ex_regwrite -> DIV_START. Else ID hazard vs ex_rd (ex_regwrite):
//     load & branch -> STALL, stall_cnt=1 (2 stall cycles total incl. detect cycle);
//     load & non-branch, or ALU & branch -> 1 stall cycle, stay RUN (cnt 0);
//     branch matches exmem_rd with exmem_memread -> 1 stall cycle.
//     Any stall cycle: stall_if=stall_id=bubble_ex=1 combinationally in detect cycle.
//   STALL: stalls asserted; stall_cnt decrements; at 0 -> RUN (rechecks hazards next cycle).
//   DIV_START: div_start=1, stall_if=stall_id=1, bubble_ex=0 (div held in EX); div_cnt=0 -> DIV_BUSY.
//   DIV_BUSY: stalls held; div_cnt++ ; div_ready=1 -> RUN, stalls drop same cycle;
//     div_cnt==DIV_TIMEOUT-1 && !div_ready -> RUN, div_timeout<=1. Ready and timeout same cycle: ready wins, no flag.
//  div_cnt saturates; never wraps. Rst in any state aborts immediately (no div_start).
//  div_start never asserted in consecutive cycles; never asserted while Rst=1.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (cycles with stall_id=1)
//    and perf_div_cnt[15:0] (div_start pulses); both cleared by Rst, saturate at all-ones.
//  Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  Package hazard_pkg: typedef enum logic[1:0] {FWD_ALU=2'b00,FWD_WB=2'b01,FWD_DIV=2'b10,
//    FWD_REG=2'b11} fwd_sel_t; typedef enum {RUN,STALL,DIV_START,DIV_BUSY} hz_state_t.
//  One sub-module: hazard_fwd_sel (pure combinational select for one operand, instanced x2).
// TESTING
//  1 lw x5 in EX (ex_memread=1), beq x5 in ID -> stall_id=1 for 2 cycles, then fwd_sel1=01.
//  2 add x6 in EX, bne x6 in ID -> 1 stall, next cycle exmem_rd=6 -> fwd_sel1=00, no stall.
//  3 div x7 in EX -> div_start 1 cycle, stalls held; div_ready after 33 cycles -> RUN, fwd_sel2=10 when beq uses x7.
//  4 DIV_TIMEOUT=8, div_ready never -> release after 8 BUSY cycles, div_timeout=1 sticky.
//  5 Rst=1 in DIV_BUSY cycle 3 -> next cycle RUN, all stalls 0, div_timeout=0.
//  6 rd=x0 in EX with load, branch reads x0 -> no stall, fwd_sel=11.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the decode-stage hazard/stall scheduler.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_ALU = 2'b00,
        FWD_WB  = 2'b01,
        FWD_DIV = 2'b10,
        FWD_REG = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        DIV_START,
        DIV_BUSY
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle of the hazard scheduler; slave is the controller, master the pipeline.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    import hazard_pkg::*;

    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2, id_is_branch;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite, ex_memread, ex_is_div;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_regwrite, exmem_memread, exmem_is_div;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_regwrite;
    logic              div_ready, div_start;
    logic              stall_if, stall_id, bubble_ex;
    fwd_sel_t          fwd_sel1, fwd_sel2;
    logic              div_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
        output ex_rd, ex_regwrite, ex_memread, ex_is_div,
        output exmem_rd, exmem_regwrite, exmem_memread, exmem_is_div,
        output memwb_rd, memwb_regwrite, div_ready,
        input  div_start, stall_if, stall_id, bubble_ex, fwd_sel1, fwd_sel2, div_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch,
        input  ex_rd, ex_regwrite, ex_memread, ex_is_div,
        input  exmem_rd, exmem_regwrite, exmem_memread, exmem_is_div,
        input  memwb_rd, memwb_regwrite, div_ready,
        output div_start, stall_if, stall_id, bubble_ex, fwd_sel1, fwd_sel2, div_timeout
    );

endinterface

// File: rtl/hazard_stall_ctrl_fwd_sel.sv
// ID-stage branch operand forward select for one source register.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_rs_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_regwrite_i,
    input  logic              exmem_memread_i,
    input  logic              exmem_is_div_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_regwrite_i,
    output fwd_sel_t          sel_o
);

    logic live;
    assign live = use_rs_i && (rs_i != '0);

    always_comb begin
        sel_o = FWD_REG;
        // A load still in EX/MEM has no data yet; the stall logic covers that case.
        if (live && rs_i == exmem_rd_i && exmem_regwrite_i && !exmem_memread_i) begin
            sel_o = exmem_is_div_i ? FWD_DIV : FWD_ALU;
        end else if (live && rs_i == memwb_rd_i && memwb_regwrite_i) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard/stall scheduler with divider launch sequencing.
// Optional HAZARD_PERF_CNT_EN adds stall-cycle and divide-launch performance counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned DIV_TIMEOUT = 40
) (
    input logic                clk,
    input logic                Rst,
    hazard_stall_ctrl_if.slave ctrl_bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [15:0]        perf_div_cnt
`endif
);

    localparam int unsigned        DivCntW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [DivCntW-1:0] DivLast = DivCntW'(DIV_TIMEOUT - 1);
    localparam logic [DivCntW-1:0] DivOne  = DivCntW'(1);

    hz_state_t          state_q, state_d;
    logic [1:0]         stall_cnt_q, stall_cnt_d;
    logic [DivCntW-1:0] div_cnt_q, div_cnt_d;
    logic               div_timeout_q, div_timeout_d;
    logic               stall, hold, launch;

    function automatic logic reg_match(logic use_rs, logic [REG_AW-1:0] rs,
                                       logic [REG_AW-1:0] rd);
        return use_rs && (rd != '0) && (rs == rd);
    endfunction

    logic ex_hit, exmem_hit, div_det, haz_load_br, haz_one;
    assign ex_hit = ctrl_bus.ex_regwrite &&
        (reg_match(ctrl_bus.id_use_rs1, ctrl_bus.id_rs1, ctrl_bus.ex_rd) ||
         reg_match(ctrl_bus.id_use_rs2, ctrl_bus.id_rs2, ctrl_bus.ex_rd));
    assign exmem_hit =
        reg_match(ctrl_bus.id_use_rs1, ctrl_bus.id_rs1, ctrl_bus.exmem_rd) ||
        reg_match(ctrl_bus.id_use_rs2, ctrl_bus.id_rs2, ctrl_bus.exmem_rd);
    assign div_det     = ctrl_bus.ex_is_div && ctrl_bus.ex_regwrite;
    assign haz_load_br = ex_hit && ctrl_bus.ex_memread && ctrl_bus.id_is_branch;
    assign haz_one     = (ex_hit && (ctrl_bus.ex_memread || ctrl_bus.id_is_branch)) ||
                         (ctrl_bus.id_is_branch && ctrl_bus.exmem_memread && exmem_hit);

    always_comb begin
        state_d       = state_q;
        stall_cnt_d   = stall_cnt_q;
        div_cnt_d     = div_cnt_q;
        div_timeout_d = div_timeout_q;
        stall         = 1'b0;
        hold          = 1'b0;
        launch        = 1'b0;
        unique case (state_q)
            RUN: begin
                if (div_det) begin
                    state_d = DIV_START;
                end else if (haz_load_br) begin
                    stall       = 1'b1;
                    stall_cnt_d = 2'd1;
                    state_d     = STALL;
                end else if (haz_one) begin
                    stall = 1'b1;
                end
            end
            STALL: begin
                stall       = 1'b1;
                stall_cnt_d = (stall_cnt_q != 2'd0) ? stall_cnt_q - 2'd1 : 2'd0;
                if (stall_cnt_q <= 2'd1) state_d = RUN;
            end
            DIV_START: begin
                launch    = 1'b1;
                hold      = 1'b1;
                div_cnt_d = '0;
                state_d   = DIV_BUSY;
            end
            DIV_BUSY: begin
                if (div_cnt_q != '1) div_cnt_d = div_cnt_q + DivOne;
                if (ctrl_bus.div_ready) begin
                    state_d = RUN;
                end else begin
                    hold = 1'b1;
                    if (div_cnt_q == DivLast) begin
                        state_d       = RUN;
                        div_timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q       <= RUN;
            stall_cnt_q   <= 2'd0;
            div_cnt_q     <= '0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            div_cnt_q     <= div_cnt_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    // Reset masks the controls combinationally so an in-flight launch is aborted at once.
    assign ctrl_bus.stall_if    = !Rst && (stall || hold);
    assign ctrl_bus.stall_id    = !Rst && (stall || hold);
    assign ctrl_bus.bubble_ex   = !Rst && stall;
    assign ctrl_bus.div_start   = !Rst && launch;
    assign ctrl_bus.div_timeout = div_timeout_q;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel1 (
        .rs_i             (ctrl_bus.id_rs1),
        .use_rs_i         (ctrl_bus.id_use_rs1),
        .exmem_rd_i       (ctrl_bus.exmem_rd),
        .exmem_regwrite_i (ctrl_bus.exmem_regwrite),
        .exmem_memread_i  (ctrl_bus.exmem_memread),
        .exmem_is_div_i   (ctrl_bus.exmem_is_div),
        .memwb_rd_i       (ctrl_bus.memwb_rd),
        .memwb_regwrite_i (ctrl_bus.memwb_regwrite),
        .sel_o            (ctrl_bus.fwd_sel1)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel2 (
        .rs_i             (ctrl_bus.id_rs2),
        .use_rs_i         (ctrl_bus.id_use_rs2),
        .exmem_rd_i       (ctrl_bus.exmem_rd),
        .exmem_regwrite_i (ctrl_bus.exmem_regwrite),
        .exmem_memread_i  (ctrl_bus.exmem_memread),
        .exmem_is_div_i   (ctrl_bus.exmem_is_div),
        .memwb_rd_i       (ctrl_bus.memwb_rd),
        .memwb_regwrite_i (ctrl_bus.memwb_regwrite),
        .sel_o            (ctrl_bus.fwd_sel2)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_div_q;

    always_ff @(posedge clk) begin
        if (Rst) begin
            perf_stall_q <= '0;
            perf_div_q   <= '0;
        end else begin
            if (ctrl_bus.stall_id && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
            if (ctrl_bus.div_start && perf_div_q != '1) perf_div_q <= perf_div_q + 16'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_div_cnt   = perf_div_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: directed pipeline scenarios followed by random traffic against a cycle model.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam int DT = 40;

    logic clk;
    logic rst;

    hazard_stall_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_div_cnt;
`endif

    hazard_stall_ctrl #(.REG_AW(5), .DIV_TIMEOUT(DT)) dut (
        .clk      (clk),
        .Rst      (rst),
        .ctrl_bus (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_div_cnt   (perf_div_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    // Model: pending extra stall cycles, divide age (-1 idle, 0 launch, k = k-th busy cycle).
    int   m_pend = 0;
    int   m_age  = -1;
    logic m_tflag = 1'b0;
    int   lat = 1;
    logic rdy_hold = 1'b0;

    function automatic logic hits(logic u, logic [4:0] rs, logic [4:0] rd);
        return u && (rd != 5'd0) && (rs == rd);
    endfunction

    function automatic logic [1:0] m_fwd(logic u, logic [4:0] rs);
        if (hits(u, rs, bus.exmem_rd) && bus.exmem_regwrite && !bus.exmem_memread)
            return bus.exmem_is_div ? 2'b10 : 2'b00;
        if (hits(u, rs, bus.memwb_rd) && bus.memwb_regwrite) return 2'b01;
        return 2'b11;
    endfunction

    task automatic clr();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0; bus.id_is_branch = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0; bus.ex_is_div = 1'b0;
        bus.exmem_rd = 5'd0; bus.exmem_regwrite = 1'b0; bus.exmem_memread = 1'b0;
        bus.exmem_is_div = 1'b0;
        bus.memwb_rd = 5'd0; bus.memwb_regwrite = 1'b0;
        bus.div_ready = 1'b0;
    endtask

    // Called right after a falling edge with inputs applied; predicts this cycle's outputs.
    task automatic step(input string tag);
        logic ds, st, bub, ld, alu, br, hit_ex, hit_em, tnext;
        int   need;
        ds = 1'b0; st = 1'b0; bub = 1'b0; tnext = m_tflag;
        br     = bus.id_is_branch;
        hit_ex = bus.ex_regwrite && (hits(bus.id_use_rs1, bus.id_rs1, bus.ex_rd) ||
                                     hits(bus.id_use_rs2, bus.id_rs2, bus.ex_rd));
        hit_em = hits(bus.id_use_rs1, bus.id_rs1, bus.exmem_rd) ||
                 hits(bus.id_use_rs2, bus.id_rs2, bus.exmem_rd);
        ld  = hit_ex && bus.ex_memread;
        alu = hit_ex && !bus.ex_memread;
        if (rst) begin
            m_pend = 0; m_age = -1; tnext = 1'b0;
        end else if (m_age == 0) begin
            ds = 1'b1; st = 1'b1; m_age = 1;
        end else if (m_age > 0) begin
            if (bus.div_ready) m_age = -1;
            else begin
                st = 1'b1;
                if (m_age >= DT) begin m_age = -1; tnext = 1'b1; end
                else m_age++;
            end
        end else if (m_pend > 0) begin
            st = 1'b1; bub = 1'b1; m_pend--;
        end else if (bus.ex_is_div && bus.ex_regwrite) begin
            m_age = 0;
        end else begin
            need = 0;
            if (ld && br) need = 2;
            else if (ld || (alu && br) || (br && bus.exmem_memread && hit_em)) need = 1;
            if (need > 0) begin st = 1'b1; bub = 1'b1; m_pend = need - 1; end
        end
        exp_q.push_back({ds, st, st, bub, m_fwd(bus.id_use_rs1, bus.id_rs1),
                         m_fwd(bus.id_use_rs2, bus.id_rs2), m_tflag});
        tag_q.push_back(tag);
        m_tflag = tnext;
        @(negedge clk);
    endtask

    logic [8:0] got, want;
    string      tg;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                tg   = tag_q.pop_front();
                got  = {bus.div_start, bus.stall_if, bus.stall_id, bus.bubble_ex,
                        bus.fwd_sel1, bus.fwd_sel2, bus.div_timeout};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s @%0t: got %b required %b (ds sif sid bub f1 f2 to)",
                             tg, $time, got, want);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        @(negedge clk);
        @(negedge clk);
        step("reset");
        rst = 1'b0;
        step("idle");

        // load-use on branch: two stall cycles, then WB forward
        bus.ex_rd = 5'd5; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_is_branch = 1'b1;
        step("lw_beq_detect");
        bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
        bus.exmem_rd = 5'd5; bus.exmem_regwrite = 1'b1; bus.exmem_memread = 1'b1;
        step("lw_beq_stall2");
        bus.exmem_rd = 5'd0; bus.exmem_regwrite = 1'b0; bus.exmem_memread = 1'b0;
        bus.memwb_rd = 5'd5; bus.memwb_regwrite = 1'b1;
        step("lw_beq_fwd_wb");

        // ALU result feeding branch: one stall, then ALU forward
        clr();
        bus.ex_rd = 5'd6; bus.ex_regwrite = 1'b1;
        bus.id_rs1 = 5'd6; bus.id_use_rs1 = 1'b1; bus.id_is_branch = 1'b1;
        step("add_bne_detect");
        bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0;
        bus.exmem_rd = 5'd6; bus.exmem_regwrite = 1'b1;
        step("add_bne_fwd_alu");

        // divide with ready after 33 busy cycles, then divider forward
        clr();
        bus.ex_rd = 5'd7; bus.ex_regwrite = 1'b1; bus.ex_is_div = 1'b1;
        step("div_detect");
        clr();
        step("div_start");
        for (int i = 0; i < 33; i++) begin
            bus.div_ready = (i == 32);
            step("div_busy");
        end
        clr();
        bus.exmem_rd = 5'd7; bus.exmem_regwrite = 1'b1; bus.exmem_is_div = 1'b1;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1; bus.id_is_branch = 1'b1;
        bus.div_ready = 1'b1;
        step("div_fwd");

        // divide never ready: timeout release and sticky flag
        clr();
        bus.ex_rd = 5'd3; bus.ex_regwrite = 1'b1; bus.ex_is_div = 1'b1;
        step("to_detect");
        clr();
        step("to_start");
        for (int i = 0; i < DT; i++) step("to_busy");
        step("to_run");
        step("to_sticky");

        // reset in the third busy cycle
        bus.ex_rd = 5'd3; bus.ex_regwrite = 1'b1; bus.ex_is_div = 1'b1;
        step("rst_detect");
        clr();
        step("rst_start");
        step("rst_busy1");
        step("rst_busy2");
        rst = 1'b1;
        step("rst_busy3");
        rst = 1'b0;
        step("rst_after");

        // x0 is never a hazard
        bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
        bus.exmem_rd = 5'd0; bus.exmem_regwrite = 1'b1;
        bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1; bus.id_is_branch = 1'b1;
        step("x0");

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.id_rs1 = 5'($urandom_range(0, 3));
            bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.id_use_rs1 = 1'($urandom_range(0, 1));
            bus.id_use_rs2 = 1'($urandom_range(0, 1));
            bus.id_is_branch = 1'($urandom_range(0, 1));
            bus.ex_rd = 5'($urandom_range(0, 3));
            bus.ex_regwrite = ($urandom_range(0, 3) != 0);
            bus.ex_memread = ($urandom_range(0, 2) == 0);
            bus.ex_is_div = ($urandom_range(0, 11) == 0);
            bus.exmem_rd = 5'($urandom_range(0, 3));
            bus.exmem_regwrite = 1'($urandom_range(0, 1));
            bus.exmem_memread = ($urandom_range(0, 2) == 0);
            bus.exmem_is_div = ($urandom_range(0, 3) == 0);
            bus.memwb_rd = 5'($urandom_range(0, 3));
            bus.memwb_regwrite = 1'($urandom_range(0, 1));
            if (m_age == 0) begin
                lat = $urandom_range(1, 45);
                bus.div_ready = rdy_hold;
                rdy_hold = 1'b0;
            end else if (m_age > 0) begin
                bus.div_ready = (m_age >= lat);
                rdy_hold = bus.div_ready;
            end else begin
                bus.div_ready = rdy_hold;
            end
            step("rand");
        end

        rst = 1'b0;
        clr();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
